// File: rtl/adc_stream_packer.sv
`default_nettype none
// ============================================================================
// adc_stream_packer : packs 16-bit ADC sample pairs into 32-bit words, buffers
// them and emits one AXI4-Stream packet of pkt_size bytes. Option macro:
// ADC_TEST_PATTERN_EN (replaces smp_data with an internal counter).
// Revision: 1.0
// ============================================================================
module adc_stream_packer #(
  parameter int SMP_W      = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int SIZE_W     = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [SIZE_W-1:0]  pkt_size,
  input  logic               smp_valid,
  input  logic [SMP_W-1:0]   smp_data,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic               size_err,
  output logic [2*SMP_W-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               m_axis_tlast
);

  localparam int CNT_W = SIZE_W - 2;
  localparam int AW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   target;
  logic [CNT_W-1:0]   pushed;
  logic [CNT_W-1:0]   beats;
  logic               phase;
  logic [SMP_W-1:0]   half;
  logic [2*SMP_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      rd_nxt;
  logic               size_good;
  logic               start_idle;
  logic               smp_acc;
  logic               word_done;
  logic               fifo_full;
  logic               pop;
  logic               push;
  logic               last_push;
  logic               head_avail;
  logic [SMP_W-1:0]   smp_val;
  logic [2*SMP_W-1:0] word;

  assign size_good  = (pkt_size != '0) && (pkt_size[1:0] == 2'b00);
  assign start_idle = start && (state == IDLE);
  assign smp_acc    = smp_valid && (state == CAPTURE);
  assign word_done  = smp_acc && phase;
  assign word       = {smp_val, half};
  assign pop        = m_axis_tvalid && m_axis_tready;
  // One slot stays unused so full and empty pointer states differ
  assign fifo_full  = (wr_ptr + AW'(1)) == rd_ptr;
  assign push       = word_done && (!fifo_full || pop);
  assign last_push  = push && ((pushed + CNT_W'(1)) == target);
  assign rd_nxt     = rd_ptr + AW'(pop);
  assign head_avail = (rd_nxt != wr_ptr);

`ifdef ADC_TEST_PATTERN_EN
  logic [SMP_W-1:0] tp_cnt;
  logic             unused_smp;
  assign unused_smp = ^smp_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tp_cnt <= '0;
    end else if (start_idle && size_good) begin
      tp_cnt <= '0;
    end else if (smp_acc) begin
      tp_cnt <= tp_cnt + SMP_W'(1);
    end
  end

  assign smp_val = tp_cnt;
`else
  assign smp_val = smp_data;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && size_good) state_nxt = CAPTURE;
      CAPTURE: if (last_push)          state_nxt = DRAIN;
      DRAIN:   if (pop && m_axis_tlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy         = (state != IDLE);
  assign m_axis_tlast = m_axis_tvalid && (beats == (target - CNT_W'(1)));
  assign done         = (state == DRAIN) && pop && m_axis_tlast;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      target   <= '0;
      pushed   <= '0;
      beats    <= '0;
      phase    <= 1'b0;
      half     <= '0;
      overflow <= 1'b0;
      size_err <= 1'b0;
    end else begin
      if (start_idle) begin
        if (size_good) begin
          target   <= pkt_size[SIZE_W-1:2];
          pushed   <= '0;
          beats    <= '0;
          phase    <= 1'b0;
          overflow <= 1'b0;
          size_err <= 1'b0;
        end else begin
          size_err <= 1'b1;
        end
      end
      if (smp_acc) begin
        phase <= ~phase;
        if (!phase) half <= smp_val;
      end
      if (push)                overflow <= overflow;
      if (push)                pushed   <= pushed + CNT_W'(1);
      if (word_done && !push)  overflow <= 1'b1;
      if (pop)                 beats    <= beats + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word;
  end

  // Output register mirrors the FIFO head; an entry leaves the FIFO on handshake
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr        <= rd_nxt;
      m_axis_tvalid <= head_avail;
      if (head_avail) m_axis_tdata <= mem[rd_nxt];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_stream_packer.sv
`default_nettype none
// Bench for adc_stream_packer: randomized stimulus checked every cycle against a
// queue-based reference model, plus literal expectations for the directed packets.
module tb_adc_stream_packer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pkt_size = 32'd0;
  logic        smp_valid = 1'b0;
  logic [15:0] smp_data = 16'd0;
  logic        m_axis_tready = 1'b0;
  logic        busy, done, overflow, size_err;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast;

  adc_stream_packer #(.SMP_W(16), .FIFO_DEPTH(DEPTH), .SIZE_W(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .pkt_size(pkt_size),
    .smp_valid(smp_valid), .smp_data(smp_data), .busy(busy), .done(done),
    .overflow(overflow), .size_err(size_err), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: words waiting for the stream, each tagged with its push cycle.
  // Usable buffering is DEPTH-1 words; a word is visible two cycles after its odd sample.
  typedef struct { logic [31:0] w; int t; } ent_t;
  ent_t        mq[$];
  int          cyc = 0;
  int          m_st = 0;
  logic [29:0] m_W = 0, m_P = 0, m_S = 0;
  bit          m_phase = 0, m_ovf = 0, m_serr = 0;
  logic [15:0] m_half = 0, m_tp = 0;
  int          done_cnt = 0;

  function automatic bit m_valid();
    return (mq.size() > 0) && (cyc >= mq[0].t + 2);
  endfunction

  always @(posedge clk or negedge resetn) begin : model
    int          st0;
    bit          pop;
    logic [15:0] v;
    ent_t        e;
    if (!resetn) begin
      mq.delete();
      m_st = 0; m_W = 0; m_P = 0; m_S = 0;
      m_phase = 0; m_ovf = 0; m_serr = 0; m_half = 0; m_tp = 0;
    end else begin
      st0 = m_st;
      pop = m_valid() && m_axis_tready;
      if (pop) begin
        mq.delete(0);
        if (st0 == 2 && m_S == m_W - 30'd1) begin
          m_st = 0;
          done_cnt++;
        end
        m_S = m_S + 30'd1;
      end
      if (st0 == 0 && start) begin
        if (pkt_size != 0 && pkt_size[1:0] == 2'b00) begin
          m_st = 1; m_W = pkt_size[31:2]; m_P = 0; m_S = 0;
          m_phase = 0; m_ovf = 0; m_serr = 0; m_tp = 0;
        end else begin
          m_serr = 1;
        end
      end else if (st0 == 1 && smp_valid) begin
`ifdef ADC_TEST_PATTERN_EN
        v = m_tp;
`else
        v = smp_data;
`endif
        m_tp = m_tp + 16'd1;
        if (!m_phase) begin
          m_half = v;
          m_phase = 1;
        end else begin
          m_phase = 0;
          if (mq.size() < DEPTH - 1) begin
            e.w = {v, m_half};
            e.t = cyc;
            mq.push_back(e);
            m_P = m_P + 30'd1;
            if (m_P == m_W) m_st = 2;
          end else begin
            m_ovf = 1;
          end
        end
      end
      cyc++;
    end
  end

  logic [31:0] blog_d[$];
  bit          blog_l[$];
  int          dut_done_cnt = 0;

  always @(negedge clk) begin : compare
    bit ev, el, ed;
    ev = m_valid();
    el = ev && (m_S == m_W - 30'd1);
    ed = (m_st == 2) && ev && m_axis_tready && el;
    chk("busy", 32'(busy), 32'(m_st != 0));
    chk("tvalid", 32'(m_axis_tvalid), 32'(ev));
    chk("tlast", 32'(m_axis_tlast), 32'(el));
    chk("done", 32'(done), 32'(ed));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("size_err", 32'(size_err), 32'(m_serr));
    if (ev) chk("tdata", m_axis_tdata, mq[0].w);
    if (m_axis_tvalid && m_axis_tready) begin
      blog_d.push_back(m_axis_tdata);
      blog_l.push_back(m_axis_tlast);
    end
    if (done) dut_done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // dmode: 0 random data, 1 counting samples, 2 constant 0xFFFF
  task automatic run_pkt(input logic [31:0] size, input int vp, input int rp,
                         input int hold, input int dmode, input bit junk);
    int          d0;
    logic [15:0] sc;
    bit          fin;
    d0 = done_cnt; sc = 16'd0; fin = 0;
    blog_d.delete(); blog_l.delete();
    start = 1'b1; pkt_size = size; smp_valid = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 0; c < 80000; c++) begin
      if (done_cnt != d0) begin
        fin = 1;
        break;
      end
      smp_valid = ($urandom_range(0, 99) < vp);
      smp_data  = (dmode == 1) ? sc : (dmode == 2) ? 16'hFFFF : 16'($urandom);
      if (smp_valid) sc = sc + 16'd1;
      m_axis_tready = (c < hold) ? 1'b0 : ($urandom_range(0, 99) < rp);
      start    = junk && ($urandom_range(0, 15) == 0);
      pkt_size = $urandom;
      tick();
    end
    start = 1'b0; smp_valid = 1'b0; m_axis_tready = 1'b0;
    chk("pkt_completed", 32'(fin), 32'd1);
  endtask

  task automatic pulse_start(input logic [31:0] size);
    start = 1'b1; pkt_size = size;
    tick();
    start = 1'b0;
    tick();
    tick();
  endtask

  // Beats hold consecutive counting samples: beat k = {2k+1, 2k}
  task automatic chk_counting(input string name, input int n);
    int errs;
    errs = 0;
    for (int i = 0; i < n && i < blog_d.size(); i++)
      if (blog_d[i] !== {16'(2 * i + 1), 16'(2 * i)}) errs++;
    chk(name, 32'(errs), 32'd0);
  endtask

  task automatic chk_last_only_final(input string name);
    int nl;
    nl = 0;
    foreach (blog_l[i]) if (blog_l[i]) nl++;
    chk({name, "_cnt"}, 32'(nl), 32'd1);
    if (blog_l.size() > 0) chk({name, "_pos"}, 32'(blog_l[blog_l.size() - 1]), 32'd1);
  endtask

  logic [31:0] t1_exp [4];

  initial begin : stim
    int dd0;
    bit fin;
    t1_exp = '{32'h00010000, 32'h00030002, 32'h00050004, 32'h00070006};

    resetn = 1'b0;
    tick(); tick();
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    tick();

    // Four-beat packet of counting samples
    dd0 = dut_done_cnt;
    run_pkt(32'd16, 100, 100, 0, 1, 0);
    chk("t1_beats", 32'(blog_d.size()), 32'd4);
    for (int i = 0; i < 4 && i < blog_d.size(); i++) begin
      chk("t1_data", blog_d[i], t1_exp[i]);
      chk("t1_last", 32'(blog_l[i]), 32'(i == 3));
    end
    chk("t1_done_pulses", 32'(dut_done_cnt - dd0), 32'd1);

    // Long packet, randomized back-pressure
    run_pkt(32'd65536, 60, 50, 0, 1, 0);
    chk("t2_beats", 32'(blog_d.size()), 32'd16384);
    chk_counting("t2_continuous", 16384);
    chk_last_only_final("t2_last");
    chk("t2_overflow", 32'(overflow), 32'd0);

    // Stalled sink forces drops; packet length stays exact
    run_pkt(32'd64, 100, 100, 200, 1, 0);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_beats", 32'(blog_d.size()), 32'd16);
    chk_counting("t3_first15", DEPTH - 1);
    chk_last_only_final("t3_last");

    // Bad sizes then a good one
    blog_d.delete(); blog_l.delete();
    pulse_start(32'd6);
    chk("t4_err6", 32'(size_err), 32'd1);
    chk("t4_busy6", 32'(busy), 32'd0);
    pulse_start(32'd0);
    chk("t4_err0", 32'(size_err), 32'd1);
    chk("t4_busy0", 32'(busy), 32'd0);
    chk("t4_nobeats", 32'(blog_d.size()), 32'd0);
    run_pkt(32'd8, 100, 100, 0, 1, 0);
    chk("t4_err_clr", 32'(size_err), 32'd0);
    chk("t4_beats", 32'(blog_d.size()), 32'd2);

    // Reset in the middle of an 8-beat packet
    blog_d.delete(); blog_l.delete();
    start = 1'b1; pkt_size = 32'd32;
    tick();
    start = 1'b0;
    fin = 0;
    for (int c = 0; c < 1000; c++) begin
      smp_valid = 1'b1; smp_data = 16'(c); m_axis_tready = 1'b1;
      if (blog_d.size() >= 2) begin
        fin = 1;
        break;
      end
      tick();
    end
    chk("t5_reached_beat3", 32'(fin), 32'd1);
    #2 resetn = 1'b0;
    smp_valid = 1'b0; m_axis_tready = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy), 32'd0);
    chk("t5_rst_done", 32'(done), 32'd0);
    chk("t5_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("t5_rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("t5_rst_tdata", m_axis_tdata, 32'd0);
    chk("t5_rst_flags", {30'd0, overflow, size_err}, 32'd0);
    tick(); tick();
    resetn = 1'b1;
    tick();
    run_pkt(32'd32, 100, 100, 0, 1, 0);
    chk("t5_beats", 32'(blog_d.size()), 32'd8);
    chk_counting("t5_data", 8);
    chk_last_only_final("t5_last");

    // Randomized packets with random data, stalls and ignored starts
    for (int k = 0; k < 8; k++) begin
      run_pkt(32'(4 * $urandom_range(1, 40)), $urandom_range(20, 100),
              $urandom_range(20, 100), 0, 0, bit'(k % 2));
      chk("rnd_beats", 32'(blog_d.size()), 32'(m_W));
    end

`ifdef ADC_TEST_PATTERN_EN
    run_pkt(32'd8, 100, 100, 0, 2, 0);
    chk("t6_beats", 32'(blog_d.size()), 32'd2);
    if (blog_d.size() == 2) begin
      chk("t6_beat0", blog_d[0], 32'h00010000);
      chk("t6_beat1", blog_d[1], 32'h00030002);
    end
`endif

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire
